axi_filter_range_cfg: RTL and testbench

//  APB-programmable range configuration feeding START_ADDR/STOP_ADDR of axi_filter_wr_channel.

---
 rtl/axi_filter_range_cfg_if.sv | 22 ++
 rtl/axi_filter_range_cfg.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_filter_range_cfg.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_filter_range_cfg_if.sv
// APB slave port bundle for the range configuration block.
// Signal names keep the block's pin names so board-level wiring reads the same.
interface axi_filter_range_cfg_if;
    logic [11:0] apb_paddr_i;
    logic        apb_psel_i;
    logic        apb_penable_i;
    logic        apb_pwrite_i;
    logic [31:0] apb_pwdata_i;
    logic [31:0] apb_prdata_o;
    logic        apb_pready_o;
    logic        apb_pslverr_o;

    modport master (
        output apb_paddr_i, apb_psel_i, apb_penable_i, apb_pwrite_i, apb_pwdata_i,
        input  apb_prdata_o, apb_pready_o, apb_pslverr_o
    );

    modport slave (
        input  apb_paddr_i, apb_psel_i, apb_penable_i, apb_pwrite_i, apb_pwdata_i,
        output apb_prdata_o, apb_pready_o, apb_pslverr_o
    );
endinterface

// File: rtl/axi_filter_range_cfg.sv
// APB-programmable address ranges for axi_filter_wr_channel.
// Software fills shadow START/STOP/ENABLE, then COMMIT copies them to the
// active set only while the filter is idle, so a burst never sees a change.
// Optional feature macro: AXI_FILTER_CFG_LOCK_EN (sticky LOCK bit in CTRL).

// One range: shadow bounds, active bounds and the registered output window.
module axi_filter_range_cfg_lane #(
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_start,
    input  logic          i_wr_stop,
    input  logic [AW-1:0] i_wdata,
    input  logic          i_en_shadow,
    input  logic          i_apply,
    output logic [AW-1:0] o_sh_start,
    output logic [AW-1:0] o_sh_stop,
    output logic [AW-1:0] o_start,
    output logic [AW-1:0] o_stop
);
    logic [AW-1:0] act_start;
    logic [AW-1:0] act_stop;
    logic          act_en;

    // Shadow bounds written by software, invisible to the filter until commit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sh_start <= '0;
            o_sh_stop  <= '0;
        end else begin
            if (i_wr_start) o_sh_start <= i_wdata;
            if (i_wr_stop)  o_sh_stop  <= i_wdata;
        end
    end

    // Active set is replaced as a whole when a commit is applied
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_start <= '0;
            act_stop  <= '0;
            act_en    <= 1'b0;
        end else if (i_apply) begin
            act_start <= o_sh_start;
            act_stop  <= o_sh_stop;
            act_en    <= i_en_shadow;
        end
    end

    // Disabled range becomes START=all-ones/STOP=0 so it can never match
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_start <= '1;
            o_stop  <= '0;
        end else begin
            o_start <= act_en ? act_start : '1;
            o_stop  <= act_en ? act_stop  : '0;
        end
    end
endmodule

module axi_filter_range_cfg #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NBR_RANGE      = 1
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    axi_filter_range_cfg_if.slave                      apb,
    input  logic                                       i_filter_idle,
    output logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0]   START_ADDR,
    output logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0]   STOP_ADDR,
    output logic                                       o_commit_pending
);
    typedef struct packed {
        logic [11:0] addr;
        logic        write;
        logic [31:0] wdata;
    } apb_req_t;

    typedef enum logic { IDLE, ACK } apb_state_e;
    typedef enum logic { C_IDLE, C_PEND } cmt_state_e;

    apb_state_e cs, ns;
    cmt_state_e c_cs, c_ns;

    apb_req_t req;
    logic     access;
    logic     is_ctrl, is_stat, is_en, is_rng, rng_stop;
    logic [8:0] rng_off;
    logic     err, wr_ok, commit_wr, apply, locked;
    logic [31:0] rd_data;
    logic [31:0] prdata_q;
    logic        slverr_q;
    logic [NBR_RANGE-1:0] en_shadow;
    logic [NBR_RANGE-1:0] wr_start, wr_stop;
    logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] sh_start, sh_stop;

    logic unused_bits;
    assign unused_bits = ^{req.addr[1:0], req.wdata};

    assign req = '{addr: apb.apb_paddr_i, write: apb.apb_pwrite_i, wdata: apb.apb_pwdata_i};

    // Only an access phase seen while idle starts a transfer; ACK ignores the held bus
    assign access = apb.apb_psel_i & apb.apb_penable_i & (cs == IDLE);

    assign o_commit_pending = (c_cs == C_PEND);
    assign apply            = (c_cs == C_PEND) & i_filter_idle;

    // Address decode, error classification and read mux
    always_comb begin
        rng_off  = req.addr[11:3] - 9'h020;
        is_ctrl  = (req.addr[11:2] == 10'h000);
        is_stat  = (req.addr[11:2] == 10'h001);
        is_en    = (req.addr[11:2] == 10'h002);
        is_rng   = (req.addr[11:3] >= 9'h020) && (int'(rng_off) < NBR_RANGE);
        rng_stop = req.addr[2];

        err = !(is_ctrl | is_stat | is_en | is_rng);
        if (req.write) begin
            if (is_stat) err = 1'b1;
            if (locked && (is_ctrl || is_en || is_rng)) err = 1'b1;
            if (o_commit_pending && (is_en || is_rng)) err = 1'b1;
        end

        wr_ok     = access & req.write & ~err;
        commit_wr = wr_ok & is_ctrl & req.wdata[0];

        rd_data = '0;
        if (is_stat) begin
            rd_data[0] = o_commit_pending;
            rd_data[1] = locked;
        end
        if (is_en) rd_data[NBR_RANGE-1:0] = en_shadow;
        for (int i = 0; i < NBR_RANGE; i++) begin
            if (is_rng && rng_off == 9'(i))
                rd_data[AXI_ADDR_WIDTH-1:0] = rng_stop ? sh_stop[i] : sh_start[i];
        end

        wr_start = '0;
        wr_stop  = '0;
        for (int i = 0; i < NBR_RANGE; i++) begin
            if (wr_ok && is_rng && rng_off == 9'(i)) begin
                wr_start[i] = ~rng_stop;
                wr_stop[i]  = rng_stop;
            end
        end
    end

    // APB handshake state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cs <= IDLE;
        else          cs <= ns;
    end

    // One wait state: every access phase spends exactly one cycle in ACK
    always_comb begin
        ns = cs;
        case (cs)
            IDLE: if (access) ns = ACK;
            ACK:  ns = IDLE;
            default: ns = IDLE;
        endcase
    end

    // Response captured at the access edge so it is valid alongside pready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prdata_q <= '0;
            slverr_q <= 1'b0;
        end else if (access) begin
            prdata_q <= (err || req.write) ? '0 : rd_data;
            slverr_q <= err;
        end else begin
            prdata_q <= '0;
            slverr_q <= 1'b0;
        end
    end

    assign apb.apb_pready_o  = (cs == ACK);
    assign apb.apb_pslverr_o = slverr_q;
    assign apb.apb_prdata_o  = prdata_q;

    // Enable shadow register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)               en_shadow <= '0;
        else if (wr_ok && is_en)    en_shadow <= req.wdata[NBR_RANGE-1:0];
    end

`ifdef AXI_FILTER_CFG_LOCK_EN
    logic lock_q;
    // Lock is sticky; only reset clears it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                            lock_q <= 1'b0;
        else if (wr_ok && is_ctrl && req.wdata[1]) lock_q <= 1'b1;
    end
    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // Commit state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) c_cs <= C_IDLE;
        else          c_cs <= c_ns;
    end

    // Pending commit waits for the filter to report idle; repeat COMMITs fold in
    always_comb begin
        c_ns = c_cs;
        case (c_cs)
            C_IDLE: if (commit_wr) c_ns = C_PEND;
            C_PEND: if (i_filter_idle) c_ns = C_IDLE;
            default: c_ns = C_IDLE;
        endcase
    end

    for (genvar g = 0; g < NBR_RANGE; g++) begin : g_lane
        axi_filter_range_cfg_lane #(.AW(AXI_ADDR_WIDTH)) u_lane (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_wr_start (wr_start[g]),
            .i_wr_stop  (wr_stop[g]),
            .i_wdata    (req.wdata[AXI_ADDR_WIDTH-1:0]),
            .i_en_shadow(en_shadow[g]),
            .i_apply    (apply),
            .o_sh_start (sh_start[g]),
            .o_sh_stop  (sh_stop[g]),
            .o_start    (START_ADDR[g]),
            .o_stop     (STOP_ADDR[g])
        );
    end
endmodule

// File: tb/tb_axi_filter_range_cfg.sv
// Randomized self-checking bench for axi_filter_range_cfg against a
// register-level reference model (shadow/active arrays, pending, lock flags).
module tb_axi_filter_range_cfg;
    localparam int W = 32;
    localparam int N = 1;
`ifdef AXI_FILTER_CFG_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_filter_idle = 1'b0;
    logic [N-1:0][W-1:0] start_addr, stop_addr;
    logic commit_pending;

    int checks = 0;
    int failures = 0;

    axi_filter_range_cfg_if apb_if();

    axi_filter_range_cfg #(.AXI_ADDR_WIDTH(W), .NBR_RANGE(N)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .apb             (apb_if),
        .i_filter_idle   (i_filter_idle),
        .START_ADDR      (start_addr),
        .STOP_ADDR       (stop_addr),
        .o_commit_pending(commit_pending)
    );

    always #5 i_clk = ~i_clk;

    // Reference model state
    logic [31:0] m_sh_start [N];
    logic [31:0] m_sh_stop  [N];
    logic [31:0] m_act_start[N];
    logic [31:0] m_act_stop [N];
    logic [N-1:0] m_en, m_act_en;
    bit m_pend, m_lock;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh_start[i] = 0; m_sh_stop[i] = 0; m_act_start[i] = 0; m_act_stop[i] = 0;
        end
        m_en = '0; m_act_en = '0; m_pend = 0; m_lock = 0;
    endtask

    task automatic model_apply();
        if (m_pend) begin
            for (int i = 0; i < N; i++) begin
                m_act_start[i] = m_sh_start[i];
                m_act_stop[i]  = m_sh_stop[i];
            end
            m_act_en = m_en;
            m_pend = 0;
        end
    endtask

    task automatic model_access(input logic [11:0] a, input logic w, input logic [31:0] d,
                                output logic e, output logic [31:0] r);
        int off, idx;
        bit rng, stop_sel;
        off = int'(a) & ~3;
        e = 1'b0; r = '0; rng = 0; idx = 0; stop_sel = 0;
        if (off >= 'h100) begin
            idx = (off - 'h100) / 8;
            stop_sel = ((off - 'h100) % 8) == 4;
            rng = idx < N;
        end
        if (off == 0) begin
            if (w) begin
                if (m_lock) e = 1'b1;
                else begin
                    if (d[0]) m_pend = 1;
                    if (d[1] && LOCK_EN) m_lock = 1;
                end
            end
        end else if (off == 4) begin
            if (w) e = 1'b1;
            else r = {30'd0, m_lock, m_pend};
        end else if (off == 8) begin
            if (w) begin
                if (m_lock || m_pend) e = 1'b1;
                else m_en = d[N-1:0];
            end else r = 32'(m_en);
        end else if (rng) begin
            if (w) begin
                if (m_lock || m_pend) e = 1'b1;
                else if (stop_sel) m_sh_stop[idx] = d;
                else m_sh_start[idx] = d;
            end else r = stop_sel ? m_sh_stop[idx] : m_sh_start[idx];
        end else begin
            e = 1'b1;
        end
    endtask

    // Full APB transfer; returns at the negedge of the pready cycle (waits=-1 on timeout)
    task automatic apb_xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output logic err, output int waits);
        @(negedge i_clk);
        apb_if.apb_paddr_i = a; apb_if.apb_pwrite_i = w; apb_if.apb_pwdata_i = d;
        apb_if.apb_psel_i = 1'b1; apb_if.apb_penable_i = 1'b0;
        @(negedge i_clk);
        apb_if.apb_penable_i = 1'b1;
        waits = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge i_clk);
            if (apb_if.apb_pready_o) begin waits = k; break; end
        end
        rd = apb_if.apb_prdata_o; err = apb_if.apb_pslverr_o;
        apb_if.apb_psel_i = 1'b0; apb_if.apb_penable_i = 1'b0;
    endtask

    // Transfer plus model update; checks stay with the callers
    task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int waits,
                        output logic [31:0] erd, output logic eerr);
        model_access(a, w, d, eerr, erd);
        apb_xfer(a, w, d, rd, err, waits);
    endtask

    task automatic test_reset();
        logic [31:0] rd, erd; logic err, eerr; int waits;
        i_rst_n = 1'b0; model_reset();
        repeat (3) @(negedge i_clk);
        checks++; if (start_addr[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_start got=%h exp=ffffffff", start_addr[0]); end
        checks++; if (stop_addr[0] !== 32'h0) begin failures++; $display("FAIL reset_stop got=%h exp=0", stop_addr[0]); end
        checks++; if ({commit_pending, apb_if.apb_pready_o, apb_if.apb_pslverr_o} !== 3'b000 || apb_if.apb_prdata_o !== 32'h0) begin
            failures++; $display("FAIL reset_flags pend/rdy/err=%b prdata=%h exp 000/0", {commit_pending, apb_if.apb_pready_o, apb_if.apb_pslverr_o}, apb_if.apb_prdata_o); end
        i_rst_n = 1'b1;
        xfer(12'h100, 1'b0, 0, rd, err, waits, erd, eerr);
        checks++; if (waits !== 1) begin failures++; $display("FAIL reset_read_waits got=%0d exp=1", waits); end
        checks++; if (rd !== erd || err !== eerr) begin failures++; $display("FAIL reset_read got=%h/%b exp=%h/%b", rd, err, erd, eerr); end
    endtask

    task automatic test_commit_idle();
        logic [31:0] rd, erd; logic err, eerr; int waits;
        i_filter_idle = 1'b1;
        xfer(12'h100, 1'b1, 32'h1000, rd, err, waits, erd, eerr);
        checks++; if (err !== eerr) begin failures++; $display("FAIL wr_start0 err got=%b exp=%b", err, eerr); end
        xfer(12'h104, 1'b1, 32'h1FFF, rd, err, waits, erd, eerr);
        xfer(12'h008, 1'b1, 32'h1, rd, err, waits, erd, eerr);
        checks++; if (err !== eerr) begin failures++; $display("FAIL wr_enable err got=%b exp=%b", err, eerr); end
        xfer(12'h000, 1'b1, 32'h1, rd, err, waits, erd, eerr);
        checks++; if (commit_pending !== 1'b1) begin failures++; $display("FAIL commit_pend_cycle got=%b exp=1", commit_pending); end
        model_apply();
        @(negedge i_clk);
        checks++; if (commit_pending !== 1'b0) begin failures++; $display("FAIL commit_pend_one_cycle got=%b exp=0", commit_pending); end
        @(negedge i_clk);
        checks++; if (start_addr[0] !== 32'h1000 || stop_addr[0] !== 32'h1FFF) begin
            failures++; $display("FAIL commit_idle_out got=%h/%h exp=00001000/00001fff", start_addr[0], stop_addr[0]); end
    endtask

    task automatic test_commit_pending();
        logic [31:0] rd, erd; logic err, eerr; int waits;
        i_filter_idle = 1'b0;
        xfer(12'h100, 1'b1, 32'h2000, rd, err, waits, erd, eerr);
        xfer(12'h104, 1'b1, 32'h2FFF, rd, err, waits, erd, eerr);
        xfer(12'h000, 1'b1, 32'h1, rd, err, waits, erd, eerr);
        repeat (3) @(negedge i_clk);
        checks++; if (commit_pending !== 1'b1) begin failures++; $display("FAIL pend_held got=%b exp=1", commit_pending); end
        checks++; if (start_addr[0] !== 32'h1000 || stop_addr[0] !== 32'h1FFF) begin
            failures++; $display("FAIL pend_out_unchanged got=%h/%h exp=00001000/00001fff", start_addr[0], stop_addr[0]); end
        xfer(12'h100, 1'b1, 32'h3000, rd, err, waits, erd, eerr);
        checks++; if (err !== 1'b1 || eerr !== 1'b1) begin failures++; $display("FAIL pend_shadow_wr err got=%b exp=1", err); end
        xfer(12'h000, 1'b1, 32'h1, rd, err, waits, erd, eerr);
        checks++; if (err !== eerr) begin failures++; $display("FAIL pend_recommit err got=%b exp=%b", err, eerr); end
        xfer(12'h004, 1'b0, 0, rd, err, waits, erd, eerr);
        checks++; if (rd !== erd || err !== eerr) begin failures++; $display("FAIL pend_status got=%h/%b exp=%h/%b", rd, err, erd, eerr); end
        i_filter_idle = 1'b1;
        repeat (3) @(negedge i_clk);
        model_apply();
        i_filter_idle = 1'b0;
        checks++; if (start_addr[0] !== 32'h2000 || stop_addr[0] !== 32'h2FFF || commit_pending !== 1'b0) begin
            failures++; $display("FAIL pend_release got=%h/%h/%b exp=00002000/00002fff/0", start_addr[0], stop_addr[0], commit_pending); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic err, eerr; int waits;
        xfer(12'h0FC, 1'b0, 0, rd, err, waits, erd, eerr);
        checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL rd_unmapped got=%h/%b exp=0/1", rd, err); end
        xfer(12'h108, 1'b1, 32'hDEAD_BEEF, rd, err, waits, erd, eerr);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL wr_idx_oob err got=%b exp=1", err); end
        xfer(12'h004, 1'b1, 32'h3, rd, err, waits, erd, eerr);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL wr_status err got=%b exp=1", err); end
        xfer(12'h100, 1'b0, 0, rd, err, waits, erd, eerr);
        checks++; if (rd !== 32'h2000 || err !== 1'b0) begin failures++; $display("FAIL no_state_change got=%h/%b exp=00002000/0", rd, err); end
        // Disabled range collapses to an empty window
        xfer(12'h008, 1'b1, 32'h0, rd, err, waits, erd, eerr);
        i_filter_idle = 1'b1;
        xfer(12'h000, 1'b1, 32'h1, rd, err, waits, erd, eerr);
        repeat (3) @(negedge i_clk);
        model_apply();
        i_filter_idle = 1'b0;
        checks++; if (start_addr[0] !== 32'hFFFF_FFFF || stop_addr[0] !== 32'h0) begin
            failures++; $display("FAIL disabled_out got=%h/%h exp=ffffffff/00000000", start_addr[0], stop_addr[0]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, d; logic err, eerr, w; int waits;
        logic [11:0] addrs [11];
        logic [11:0] a;
        addrs = '{12'h000, 12'h004, 12'h008, 12'h100, 12'h104, 12'h108, 12'h10C,
                  12'h0FC, 12'h00C, 12'h200, 12'hFFC};
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                i_filter_idle = 1'b1;
                repeat (3) @(negedge i_clk);
                model_apply();
                i_filter_idle = 1'b0;
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (start_addr[i] !== (m_act_en[i] ? m_act_start[i] : 32'hFFFF_FFFF) ||
                        stop_addr[i]  !== (m_act_en[i] ? m_act_stop[i]  : 32'h0)) begin
                        failures++; $display("FAIL rand_out[%0d] got=%h/%h exp=%h/%h", i, start_addr[i], stop_addr[i],
                            m_act_en[i] ? m_act_start[i] : 32'hFFFF_FFFF, m_act_en[i] ? m_act_stop[i] : 32'h0);
                    end
                end
                checks++; if (commit_pending !== m_pend) begin failures++; $display("FAIL rand_pend got=%b exp=%b", commit_pending, m_pend); end
            end else begin
                a = addrs[$urandom_range(0, 10)] | 12'($urandom_range(0, 3));
                w = 1'($urandom_range(0, 1));
                d = $urandom();
                if ((a & 12'hFFC) == 12'h000) d = d & ~32'h2;
                xfer(a, w, d, rd, err, waits, erd, eerr);
                checks++;
                if (waits !== 1 || rd !== erd || err !== eerr) begin
                    failures++; $display("FAIL rand_xfer a=%h w=%b got=%h/%b/%0d exp=%h/%b/1", a, w, rd, err, waits, erd, eerr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic err, eerr; int waits;
        i_filter_idle = 1'b0;
        xfer(12'h000, 1'b1, 32'h1, rd, err, waits, erd, eerr);
        @(negedge i_clk);
        apb_if.apb_paddr_i = 12'h100; apb_if.apb_pwrite_i = 1'b1; apb_if.apb_pwdata_i = 32'h5555;
        apb_if.apb_psel_i = 1'b1; apb_if.apb_penable_i = 1'b0;
        @(negedge i_clk);
        apb_if.apb_penable_i = 1'b1;
        i_rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        checks++; if (apb_if.apb_pready_o !== 1'b0 || commit_pending !== 1'b0 || start_addr[0] !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL reset_mid got rdy=%b pend=%b start=%h exp 0/0/ffffffff", apb_if.apb_pready_o, commit_pending, start_addr[0]); end
        apb_if.apb_psel_i = 1'b0; apb_if.apb_penable_i = 1'b0;
        i_rst_n = 1'b1;
        xfer(12'h004, 1'b0, 0, rd, err, waits, erd, eerr);
        checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL reset_mid_status got=%h/%b exp=0/0", rd, err); end
        xfer(12'h100, 1'b0, 0, rd, err, waits, erd, eerr);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_mid_shadow got=%h exp=0", rd); end
    endtask

    task automatic test_lock();
        logic [31:0] rd, erd; logic err, eerr; int waits;
        xfer(12'h000, 1'b1, 32'h2, rd, err, waits, erd, eerr);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL lock_set err got=%b exp=0", err); end
        xfer(12'h100, 1'b1, 32'h1234, rd, err, waits, erd, eerr);
        checks++; if (err !== (LOCK_EN ? 1'b1 : 1'b0) || err !== eerr) begin failures++; $display("FAIL lock_wr_start err got=%b exp=%b", err, LOCK_EN); end
        xfer(12'h004, 1'b0, 0, rd, err, waits, erd, eerr);
        checks++; if (rd !== (LOCK_EN ? 32'h2 : 32'h0) || rd !== erd) begin failures++; $display("FAIL lock_status got=%h exp=%h", rd, LOCK_EN ? 32'h2 : 32'h0); end
        xfer(12'h000, 1'b1, 32'h1, rd, err, waits, erd, eerr);
        checks++; if (err !== eerr) begin failures++; $display("FAIL lock_ctrl err got=%b exp=%b", err, eerr); end
        xfer(12'h100, 1'b0, 0, rd, err, waits, erd, eerr);
        checks++; if (rd !== erd || err !== 1'b0) begin failures++; $display("FAIL lock_read got=%h/%b exp=%h/0", rd, err, erd); end
    endtask

    initial begin
        apb_if.apb_paddr_i = '0; apb_if.apb_psel_i = 1'b0; apb_if.apb_penable_i = 1'b0;
        apb_if.apb_pwrite_i = 1'b0; apb_if.apb_pwdata_i = '0;
        test_reset();
        test_commit_idle();
        test_commit_pending();
        test_errors();
        test_random();
        test_reset_mid();
        test_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
